led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Parametrised successor to the fixed divide-and-count LED blinker.
- Programmable prescaler produces a tick strobe; a wide tick counter drives N_LED outputs in one of four runtime-selectable display modes: binary count, bounce scanner, PWM breathing, static pattern.
- Sits between the board clock and the LED pins on the openXC7 bring-up designs.

Parameters:
- N_LED, 8, number of LED outputs (>=1).
- COUNT_W, 32, tick counter width (>= max(N_LED, 9)).
- PRESCALE_W, 16, width of the div input and the prescaler counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable; low freezes all counters.
- mode  input  2  0=COUNT, 1=SCAN, 2=BREATHE, 3=STATIC.
- div  input  PRESCALE_W  tick period minus one, in clk cycles.
- pattern  input  N_LED  LED value used in STATIC mode.
- tick  output  1  registered one-cycle strobe per prescaler wrap.
- led  output  N_LED  registered LED drive.

Behaviour:
- Reset (async, rst_n=0): pre=0, count=0, tick=0, led=0, pwm=0, scan pos=one-hot bit0, dir=up. Release is synchronous to the next clk edge.
- Prescaler: with en=1, if pre>=div then pre<=0 and tick<=1, else pre<=pre+1 and tick<=0.
  - div=0 gives tick every enabled cycle.
  - Lowering div below the current pre wraps on the next cycle; no long stall.
  - en=0: pre holds, tick<=0.
- Tick counter: count<=count+1 on each cycle where tick=1 and en=1; wraps 2^COUNT_W-1 -> 0.
- Scanner: advances on the same condition as count.
  - dir=up: pos shifts left.
  - At bit N_LED-1, dir flips to down and pos shifts right on the next advance; at bit0, dir flips to up.
  - Ends are lit for one step each, never two.
  - N_LED=1: pos stays 1.
- PWM: 8-bit pwm increments every clk with en=1, wraps at 255.
  - phase = count[COUNT_W-1 -: 9].
  - duty = phase[8] ? ~phase[7:0] : phase[7:0].
  - bright = (pwm < duty).
- led<= next cycle (1-cycle latency from state/inputs):
  - COUNT: count[COUNT_W-1 -: N_LED].
  - SCAN: pos.
  - BREATHE: {N_LED{bright}}.
  - STATIC: pattern.
- All internal state runs regardless of mode. A mode change affects led on the next edge and does not reset counters.
- en=0: led still re-evaluated each cycle from the frozen state, so STATIC follows pattern and mode changes still apply.
- Simultaneous events: mode change on a tick cycle shows the new mode of the post-tick state one cycle later.

Optional Feature:
- Macro LED_ACTIVE_LOW_EN.
- Defined: led is the bitwise inverse of the value above, and the reset value of led is all ones (LEDs dark on active-low boards).
- Undefined: active-high, reset value 0.
- tick and internal state are identical in both builds.

Test Plan:
- Reset: assert rst_n=0 mid-run with mode=0 -> led=0, tick=0 immediately (async), before any clk edge; after release, first tick occurs div+1 cycles later.
- Prescaler: div=3, en=1 -> tick high exactly 1 of every 4 cycles; change div 3->1 while pre=3 -> tick on next cycle, then every 2 cycles.
- COUNT: COUNT_W=12, N_LED=8, div=0 -> after 16 ticks led=8'h01; after 4096 ticks count wraps and led=8'h00.
- SCAN: N_LED=4, div=0 -> led sequence after each tick 1,2,4,8,4,2,1,2; en=0 for 5 cycles holds led value and tick=0.
- BREATHE: force count so phase=9'h040 -> led all ones for 64 of every 256 cycles; phase=9'h1C0 -> duty=0x3F, on 63 of 256.
- STATIC/mode switch: mode=3, pattern=8'hA5 -> led=8'hA5 one cycle later; with LED_ACTIVE_LOW_EN, led=8'h5A and reset led=8'hFF.

Source files
------------

// File: rtl/led_pattern_gen.sv
// Prescaled LED pattern generator: binary count, bounce scan, PWM breathing or static pattern.
// Define LED_ACTIVE_LOW_EN to invert led (and reset it to all ones) for active-low boards.
module led_pattern_gen #(
    parameter int unsigned N_LED      = 8,
    parameter int unsigned COUNT_W    = 32,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] div,
    input  logic [N_LED-1:0]      pattern,
    output logic                  tick,
    output logic [N_LED-1:0]      led
);

    localparam logic [1:0] ModeCount   = 2'd0;
    localparam logic [1:0] ModeScan    = 2'd1;
    localparam logic [1:0] ModeBreathe = 2'd2;
    localparam logic [1:0] ModeStatic  = 2'd3;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [N_LED-1:0] LedInvert = '1;
`else
    localparam logic [N_LED-1:0] LedInvert = '0;
`endif

    logic [PRESCALE_W-1:0] pre_q;
    logic [COUNT_W-1:0]    count_q;
    logic [N_LED-1:0]      pos_q;
    logic [N_LED-1:0]      pos_d;
    logic                  dir_q;   // 0 = moving up, 1 = moving down
    logic                  dir_d;
    logic [7:0]            pwm_q;
    logic                  advance;
    logic [8:0]            phase;
    logic [7:0]            duty;
    logic                  bright;
    logic [N_LED-1:0]      led_val;

    assign advance = tick & en;
    assign phase   = count_q[COUNT_W-1 -: 9];
    assign duty    = phase[8] ? ~phase[7:0] : phase[7:0];
    assign bright  = (pwm_q < duty);

    // Turn around at an end so each end is lit for exactly one step.
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (N_LED > 1) begin
            if (dir_q ? pos_q[0] : !pos_q[N_LED-1]) begin
                pos_d = pos_q << 1;
                dir_d = 1'b0;
            end else begin
                pos_d = pos_q >> 1;
                dir_d = 1'b1;
            end
        end
    end

    always_comb begin
        led_val = '0;
        case (mode)
            ModeCount:   led_val = count_q[COUNT_W-1 -: N_LED];
            ModeScan:    led_val = pos_q;
            ModeBreathe: led_val = {N_LED{bright}};
            ModeStatic:  led_val = pattern;
            default:     led_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            count_q <= '0;
            pos_q   <= N_LED'(1);
            dir_q   <= 1'b0;
            pwm_q   <= '0;
            tick    <= 1'b0;
            led     <= LedInvert;
        end else begin
            if (en) begin
                // >= so that lowering div below pre wraps at once instead of stalling.
                if (pre_q >= div) begin
                    pre_q <= '0;
                    tick  <= 1'b1;
                end else begin
                    pre_q <= pre_q + PRESCALE_W'(1);
                    tick  <= 1'b0;
                end
                pwm_q <= pwm_q + 8'd1;
            end else begin
                tick <= 1'b0;
            end

            if (advance) begin
                count_q <= count_q + COUNT_W'(1);
                pos_q   <= pos_d;
                dir_q   <= dir_d;
            end

            led <= led_val ^ LedInvert;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: an 8-LED/12-bit-count instance and a 4-LED instance.
module tb_led_pattern_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] div;
    logic [7:0]  pattern;
    logic [3:0]  pattern4;
    logic        tick;
    logic        tick4;
    logic [7:0]  led;
    logic [3:0]  led4;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int ones   = 0;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    led_pattern_gen #(
        .N_LED      (8),
        .COUNT_W    (12),
        .PRESCALE_W (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .div     (div),
        .pattern (pattern),
        .tick    (tick),
        .led     (led)
    );

    led_pattern_gen #(
        .N_LED      (4),
        .COUNT_W    (12),
        .PRESCALE_W (16)
    ) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .div     (div),
        .pattern (pattern4),
        .tick    (tick4),
        .led     (led4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] e8(input logic [7:0] v);
        return v ^ {8{INV}};
    endfunction

    function automatic logic [7:0] e4(input logic [3:0] v);
        return {4'b0, v ^ {4{INV}}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        mode     = 2'd0;
        div      = 16'd3;
        pattern  = 8'h00;
        pattern4 = 4'h0;
        step();
        step();
        chk("reset_led", led, e8(8'h00));
        chk("reset_led4", {4'b0, led4}, e4(4'h0));
        chk("reset_tick", {7'b0, tick}, 8'd0);

        // Prescaler: div=3 ticks on every 4th cycle, first one div+1 cycles after release.
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("tick_div3", {7'b0, tick}, (k == 4) ? 8'd1 : 8'd0);
        end
        // pre is 3 here; lowering div to 1 must wrap on the very next cycle.
        div = 16'd1;
        step();
        chk("tick_div_lowered", {7'b0, tick}, 8'd1);
        step();
        chk("tick_div1_a", {7'b0, tick}, 8'd0);
        step();
        chk("tick_div1_b", {7'b0, tick}, 8'd1);
        step();
        chk("tick_div1_c", {7'b0, tick}, 8'd0);
        step();
        chk("tick_div1_d", {7'b0, tick}, 8'd1);

        // Static pattern one cycle after mode change.
        mode     = 2'd3;
        pattern  = 8'hA5;
        pattern4 = 4'h5;
        step();
        chk("static_led", led, e8(8'hA5));
        chk("static_led4", {4'b0, led4}, e4(4'h5));
        step();
        chk("tick_before_reset", {7'b0, tick}, 8'd1);

        // Asynchronous reset mid-cycle, checked before the next clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_led", led, e8(8'h00));
        chk("async_reset_tick", {7'b0, tick}, 8'd0);
        chk("async_reset_led4", {4'b0, led4}, e4(4'h0));

        // COUNT mode, div=0: count after edge k is k-1, led shows count[11:4] one edge later.
        div  = 16'd0;
        mode = 2'd0;
        en   = 1'b1;
        step();
        chk("reset_held_led", led, e8(8'h00));
        rst_n = 1'b1;
        cyc   = 0;
        step();
        chk("first_tick_div0", {7'b0, tick}, 8'd1);
        run_to(17);
        chk("count_15", led, e8(8'h00));
        run_to(18);
        chk("count_16", led, e8(8'h01));
        run_to(293);
        chk("count_0x123", led, e8(8'h12));
        run_to(4097);
        chk("count_4095", led, e8(8'hFF));
        run_to(4098);
        chk("count_wrap", led, e8(8'h00));

        // BREATHE with count frozen at 0x200 (phase 0x040, duty 64).
        run_to(4608);
        div  = 16'd1000;
        mode = 2'd2;
        run_to(4609);
        ones = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (led === e8(8'hFF)) ones++;
        end
        chk("breathe_duty_0x40", 8'(ones), 8'd64);

        // BREATHE with count frozen at 0xE00 (phase 0x1C0, duty 0x3F).
        div = 16'd0;
        run_to(7937);
        div = 16'd1000;
        run_to(7938);
        ones = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (led === e8(8'hFF)) ones++;
        end
        chk("breathe_duty_0x3f", 8'(ones), 8'd63);

        // SCAN: fresh reset, div=0.
        rst_n = 1'b0;
        mode  = 2'd1;
        div   = 16'd0;
        en    = 1'b1;
        step();
        rst_n = 1'b1;
        cyc   = 0;
        step();
        begin
            logic [3:0] scan_exp [8];
            scan_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
            for (int k = 0; k < 8; k++) begin
                step();
                chk("scan4_seq", {4'b0, led4}, e4(scan_exp[k]));
            end
        end
        chk("scan8_top", led, e8(8'h80));

        // Disable for 5 cycles: led holds and no ticks.
        en = 1'b0;
        step();
        chk("scan8_turn", led, e8(8'h40));
        chk("hold_led4_0", {4'b0, led4}, e4(4'h4));
        chk("hold_tick_0", {7'b0, tick4}, 8'd0);
        for (int k = 11; k <= 14; k++) begin
            step();
            chk("hold_led4", {4'b0, led4}, e4(4'h4));
            chk("hold_tick", {7'b0, tick4}, 8'd0);
        end
        en = 1'b1;
        run_to(16);
        chk("resume_led4_wait", {4'b0, led4}, e4(4'h4));
        run_to(17);
        chk("resume_led4", {4'b0, led4}, e4(4'h8));

        // Mode switch to STATIC and back to SCAN keeps the scanner running.
        mode     = 2'd3;
        pattern  = 8'h3C;
        pattern4 = 4'h9;
        step();
        chk("static_led_b", led, e8(8'h3C));
        chk("static_led4_b", {4'b0, led4}, e4(4'h9));
        mode = 2'd1;
        step();
        chk("scan_after_static", {4'b0, led4}, e4(4'h2));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
